// File: rtl/traffic_path_scheduler.sv
// traffic_path_scheduler
// Round-robin green-phase scheduler for four intersection approaches.
// Each green is bounded by MIN_GREEN/MAX_GREEN dwell, and every green is
// followed by exactly CLEAR cycles of clearance before path_index may move.
// Pedestrian presses are latched in walk_pending until their path is granted.
module traffic_path_scheduler #(
   parameter int MIN_GREEN = 8,
   parameter int MAX_GREEN = 32,
   parameter int CLEAR     = 4,
   parameter int CNT_W     = 6
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] car_req,
   input  logic [3:0] walk_btn,
   output logic [1:0] path_index,
   output logic       green,
   output logic       clear,
   output logic       walk_serve,
   output logic [3:0] walk_pending
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GREEN = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_timer;
   logic [1:0]       r_last;

   logic [3:0] w_req;
   logic [3:0] w_other;
   logic [1:0] w_pick;
   logic       w_arb;
   logic       w_grant;
   logic       w_green_exit;
   logic [3:0] w_pending_nxt;

   // Any live request: vehicle presence, latched walks, or a press this cycle.
   assign w_req   = car_req | walk_pending | walk_btn;
   assign w_other = w_req & ~(4'b0001 << path_index);

   // Round-robin pick: first requesting path after the last granted one.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first;
      // without it an unassigned path infers a latch.
      w_pick = r_last;
      // Scan farthest-first so the nearest requester (smallest k) wins.
      for (int k = 4; k >= 1; k--) begin
         if (w_req[r_last + 2'(k)]) w_pick = r_last + 2'(k);
      end
   end

   // Arbitration happens only while idle or on the final clearance cycle.
   assign w_arb   = (r_state == ST_IDLE) ||
                    ((r_state == ST_CLEAR) && (r_timer == CLEAR_LAST));
   assign w_grant = w_arb && (w_req != 4'b0000);

   // Green ends at MAX, or after MIN once someone else waits or the car left.
   assign w_green_exit = (r_state == ST_GREEN) &&
                         (((r_timer >= MIN_LAST) &&
                           ((w_other != 4'b0000) || !car_req[path_index])) ||
                          (r_timer == MAX_LAST));

   // Latch new presses; a grant clears its path, winning over a same-cycle press.
   assign w_pending_nxt = (walk_pending | walk_btn) &
                          ~(w_grant ? (4'b0001 << w_pick) : 4'b0000);

   // Phase sequencing, dwell timer and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_last       <= 2'd3;
         path_index   <= 2'd0;
         green        <= 1'b0;
         clear        <= 1'b0;
         walk_serve   <= 1'b0;
         walk_pending <= 4'b0000;
      end else begin
         // NOTE: state registers use non-blocking assignment so every
         // right-hand side sees pre-edge values regardless of statement order.
         walk_pending <= w_pending_nxt;
         if (w_grant) begin
            r_state    <= ST_GREEN;
            r_timer    <= '0;
            r_last     <= w_pick;
            path_index <= w_pick;
            green      <= 1'b1;
            clear      <= 1'b0;
            walk_serve <= walk_pending[w_pick] | walk_btn[w_pick];
         end else begin
            case (r_state)
               ST_GREEN: begin
                  if (w_green_exit) begin
                     r_state    <= ST_CLEAR;
                     r_timer    <= '0;
                     green      <= 1'b0;
                     clear      <= 1'b1;
                     walk_serve <= 1'b0;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               ST_CLEAR: begin
                  if (r_timer == CLEAR_LAST) begin
                     // Clearance done with nothing waiting: fall back to idle.
                     r_state <= ST_IDLE;
                     r_timer <= '0;
                     clear   <= 1'b0;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_timer    <= '0;
                  green      <= 1'b0;
                  clear      <= 1'b0;
                  walk_serve <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_traffic_path_scheduler.sv
// tb_traffic_path_scheduler
// Drives directed scenarios plus randomized segments and compares every
// output, every cycle, against a phase/age reference model of the scheduler.
module tb_traffic_path_scheduler;

   localparam int MIN_GREEN = 8;
   localparam int MAX_GREEN = 32;
   localparam int CLEAR     = 4;
   localparam int CNT_W     = 6;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] car_req = 4'b0000;
   logic [3:0] walk_btn = 4'b0000;
   logic [1:0] path_index;
   logic       green;
   logic       clear;
   logic       walk_serve;
   logic [3:0] walk_pending;

   int checks = 0;
   int failures = 0;

   // Reference model: phase flags plus the count of cycles spent in the phase.
   int       m_path;
   int       m_last;
   bit       m_green;
   bit       m_clear;
   bit       m_serve;
   bit [3:0] m_pend;
   int       m_age;

   traffic_path_scheduler #(
      .MIN_GREEN(MIN_GREEN),
      .MAX_GREEN(MAX_GREEN),
      .CLEAR    (CLEAR),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .car_req     (car_req),
      .walk_btn    (walk_btn),
      .path_index  (path_index),
      .green       (green),
      .clear       (clear),
      .walk_serve  (walk_serve),
      .walk_pending(walk_pending)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_path  = 0;
      m_last  = 3;
      m_green = 0;
      m_clear = 0;
      m_serve = 0;
      m_pend  = 4'b0000;
      m_age   = 0;
   endtask

   // One clock edge of the scheduling rules, using the inputs seen at that edge.
   task automatic model_step(input bit [3:0] car, input bit [3:0] btn);
      bit [3:0] req;
      bit [3:0] other;
      bit [3:0] new_pend;
      int       pick;
      bit       arb;
      req  = car | m_pend | btn;
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
         int p;
         p = (m_last + k) % 4;
         if (pick < 0 && req[p]) pick = p;
      end
      new_pend = m_pend | btn;
      arb = (!m_green && !m_clear) || (m_clear && m_age == CLEAR);
      if (arb) begin
         if (pick >= 0) begin
            m_serve        = m_pend[pick] | btn[pick];
            new_pend[pick] = 1'b0;
            m_path  = pick;
            m_last  = pick;
            m_green = 1;
            m_clear = 0;
            m_age   = 1;
         end else begin
            m_green = 0;
            m_clear = 0;
            m_age   = 0;
         end
      end else if (m_green) begin
         other = req;
         other[m_path] = 1'b0;
         if ((m_age >= MIN_GREEN && (other != 0 || !car[m_path])) || m_age == MAX_GREEN) begin
            m_green = 0;
            m_clear = 1;
            m_serve = 0;
            m_age   = 1;
         end else begin
            m_age++;
         end
      end else begin
         m_age++;
      end
      m_pend = new_pend;
   endtask

   task automatic compare_all();
      check("path_index", path_index, m_path);
      check("green", green, m_green);
      check("clear", clear, m_clear);
      check("walk_serve", walk_serve, m_serve);
      check("walk_pending", walk_pending, m_pend);
   endtask

   // Drive inputs on the falling edge, step the model on the rising edge,
   // then sample the DUT just after it.
   task automatic cycle(input logic [3:0] car, input logic [3:0] btn);
      @(negedge clk);
      car_req  = car;
      walk_btn = btn;
      @(posedge clk);
      model_step(car, btn);
      #1;
      compare_all();
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic async_reset();
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("rst_path_index", path_index, 0);
      check("rst_green", green, 0);
      check("rst_clear", clear, 0);
      check("rst_walk_serve", walk_serve, 0);
      check("rst_walk_pending", walk_pending, 0);
      model_reset();
      car_req  = 4'b0000;
      walk_btn = 4'b0000;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      model_reset();
      #12;
      rstn = 1'b1;
      compare_all();

      // No requests: everything stays quiet.
      repeat (20) cycle(4'b0000, 4'b0000);

      // Single path held: MAX-length greens with clearances, repeating.
      repeat (80) cycle(4'b0100, 4'b0000);
      repeat (10) cycle(4'b0000, 4'b0000);

      // Two paths held: MIN-length greens alternating between them.
      repeat (50) cycle(4'b0101, 4'b0000);
      repeat (20) cycle(4'b0000, 4'b0000);

      // Pedestrian only on path 3.
      cycle(4'b0000, 4'b1000);
      repeat (20) cycle(4'b0000, 4'b0000);

      // Short car pulse on path 1, then a walk press during its green.
      repeat (3) cycle(4'b0010, 4'b0000);
      repeat (3) cycle(4'b0000, 4'b0000);
      cycle(4'b0000, 4'b0010);
      repeat (30) cycle(4'b0000, 4'b0000);

      // Reset mid-green on path 2 with walks pending on paths 0 and 1.
      async_reset();
      cycle(4'b0100, 4'b0000);
      cycle(4'b0100, 4'b0011);
      repeat (4) cycle(4'b0100, 4'b0000);
      check("pre_rst_green", green, 1);
      check("pre_rst_path", path_index, 2);
      check("pre_rst_pending", walk_pending, 4'b0011);
      async_reset();
      cycle(4'b1111, 4'b0000);
      check("post_rst_first_path", path_index, 0);
      check("post_rst_first_green", green, 1);
      repeat (40) cycle(4'b1111, 4'b0000);

      // Randomized segments with varied request density.
      for (int seg = 0; seg < 40; seg++) begin
         int mode;
         int len;
         logic [3:0] hold;
         mode = $urandom_range(0, 3);
         len  = $urandom_range(10, 60);
         hold = 4'($urandom);
         if (seg == 20) async_reset();
         for (int c = 0; c < len; c++) begin
            logic [3:0] car;
            logic [3:0] btn;
            car = 4'b0000;
            btn = 4'b0000;
            case (mode)
               0: car = 4'b0000;
               1: begin
                  car = hold;
                  if ($urandom_range(0, 19) == 0) btn = 4'($urandom);
               end
               2: begin
                  car = 4'($urandom) & 4'($urandom);
                  if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
               end
               default: begin
                  if ($urandom_range(0, 9) == 0) btn = 4'($urandom);
               end
            endcase
            cycle(car, btn);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
